ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register, consumes its decoded operation and operands, and produces the write-back fields for the EX/MEM register. Logic, shift, add/sub and set-less-than results are produced combinationally in the same cycle. DIV/DIVU run on an internal 32-iteration radix-2 divider that holds the pipeline through `stallreq_o` until the HI/LO result is ready.

## Interface
- `DIV_CYCLES`, 32: number of quotient-bit iterations; fixed to data width.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `alusel_i` in 3: result class (`EXE_RES_NOP/LOGIC/SHIFT/ARITHMETIC`, from define.v).
- `aluop_i` in 8: operation (`EXE_*_OP`, from define.v).
- `reg1_i` in 32: operand A; carries the shift amount for shifts.
- `reg2_i` in 32: operand B.
- `wd_i` in 5: destination register.
- `wreg_i` in 1: destination write enable.
- `wd_o` out 5: destination register.
- `wreg_o` out 1: write enable after overflow suppression.
- `wdata_o` out 32: GPR result.
- `whilo_o` out 1: HI/LO write strobe.
- `hi_o` out 32: remainder.
- `lo_o` out 32: quotient.
- `stallreq_o` out 1: stall request to ctrl, consumed as stall[3:0].

## Operation
- LOGIC: AND, OR, XOR, NOR on `reg1_i`/`reg2_i`.
- SHIFT: SLL, SRL, SRA of `reg2_i` by `reg1_i[4:0]`. SRA sign-fills.
- ARITHMETIC:
  - ADD/ADDU/SUB/SUBU use 32-bit wrap arithmetic.
  - For ADD and SUB, signed overflow forces `wreg_o`=0. `wdata_o` still carries the wrapped sum.
  - SLT compares signed; SLTU compares unsigned. The result is 0 or 1.
- NOP or an unknown op gives `wdata_o`=0. `wd_o` and `wreg_o` pass through.
- Divider FSM:
  - States are IDLE, BUSY and DONE, with a 5-bit counter.
  - The divider holds a 64-bit remainder/dividend shift register, a 32-bit divisor and two sign flags.
- IDLE with `aluop_i`∈{DIV, DIVU} and divisor ≠ 0:
  - Latch |A| and |B|. These are magnitudes for DIV and raw values for DIVU.
  - Latch the quotient sign (A xor B) and the remainder sign (A).
  - Counter ← 0; go to BUSY.
- IDLE with a DIV/DIVU op and divisor = 0: go to DONE with quotient=0 and remainder=0.
- BUSY, each cycle:
  - Shift left by 1.
  - Trial-subtract the divisor from the upper 33 bits.
  - On a non-negative difference, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - At counter=31, go to DONE. Otherwise increment the counter.
- DONE:
  - Apply sign correction (two's complement) for DIV.
  - Present `lo_o`=quotient, `hi_o`=remainder, `whilo_o`=1.
  - Go to IDLE unconditionally on the next edge.
- `stallreq_o` = (IDLE and a div op present) or BUSY. It is 0 in DONE, so ID/EX advances at the DONE edge and the division is not relaunched.
- Divider outputs: `whilo_o`=0 outside DONE; `hi_o` and `lo_o` read 0 outside DONE.
- Divide ops are GPR-silent: `wreg_o` is forced to 0 for DIV/DIVU.
- Quotient sign rules: the remainder takes the dividend's sign. 0x80000000 / -1 gives quotient 0x80000000 and remainder 0. Overflow is not flagged.

## Timing
- Non-divide ops have zero latency: outputs are combinational from the inputs in the same cycle.
- Divide, divisor ≠ 0:
  - The op appears in cycle T0 and `stallreq_o`=1 for T0..T32.
  - DONE occurs in T33, with a result strobe for one cycle.
  - The next instruction enters EX at T34.
- Divide by zero: stall in T0 only, DONE in T1.
- While the stall is held, ctrl freezes ID/EX and keeps `aluop_i` constant. The FSM ignores input changes while in BUSY and DONE.
- Reset, asynchronous, any time including mid-BUSY:
  - State ← IDLE; counter and divider registers ← 0.
  - While `rst`=1, all outputs are forced to 0, including `stallreq_o` and `whilo_o`.
- First divide after reset release behaves normally, with no residual count.

## Test plan
- ADD 0x7FFFFFFF+1 with wreg_i=1 -> wdata_o=0x80000000, wreg_o=0. ADDU with the same operands -> wreg_o=1.
- SRA reg2=0x80000010, reg1=4 -> 0xF8000001. SLT 0xFFFFFFFF vs 1 -> 1. SLTU with the same operands -> 0.
- DIV -7 / 2 held under stall -> stallreq_o high exactly 33 cycles. Then one cycle with whilo_o=1, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0x10 -> lo_o=0x0FFFFFFF, hi_o=0xF, after the same 33-cycle stall.
- DIV x / 0 -> one stall cycle, then DONE with hi_o=lo_o=0. Back-to-back DIV following the first DIV -> the second starts cleanly with no lost or duplicated strobe.
- Assert rst at BUSY counter=10 -> stallreq_o drops immediately. After release a new DIV 100/7 -> lo_o=14, hi_o=2.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle logic/shift/arith results plus a
// 32-iteration restoring divider that stalls the pipeline for DIV/DIVU.
//
// state  | meaning
// S_IDLE | no divide in flight; launches on a DIV/DIVU op
// S_BUSY | one quotient bit per cycle, counter 0..31
// S_DONE | signed-corrected HI/LO presented with whilo_o for one cycle
module ex_stage #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  alusel_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   localparam logic [2:0] EXE_RES_NOP        = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
   localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

   localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
   localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
   localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
   localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
   localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

   div_state_t  state;
   logic [4:0]  cnt;
   logic [63:0] rem_q;
   logic [31:0] divisor_q;
   logic        sign_q;
   logic        sign_r;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   logic        is_div;
   logic        signed_div;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] trial;
   logic [63:0] rem_next;

   logic [31:0] sum;
   logic [31:0] diff;
   logic        ov;
   logic [31:0] logic_res;
   logic [31:0] shift_res;
   logic [31:0] arith_res;
   logic [31:0] result;

   assign is_div     = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
   assign signed_div = (aluop_i == EXE_DIV_OP);
   assign abs_a      = (signed_div && reg1_i[31]) ? -reg1_i : reg1_i;
   assign abs_b      = (signed_div && reg2_i[31]) ? -reg2_i : reg2_i;

   // Remainder never exceeds the divisor, so a non-negative difference fits 32 bits.
   always_comb begin
      trial = rem_q[63:31] - {1'b0, divisor_q};
      if (trial[32])
         rem_next = {rem_q[62:0], 1'b0};
      else
         rem_next = {trial[31:0], rem_q[30:0], 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         res_hi    <= '0;
         res_lo    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (is_div) begin
                  if (reg2_i == 32'd0) begin
                     res_hi <= '0;
                     res_lo <= '0;
                     state  <= S_DONE;
                  end else begin
                     rem_q     <= {32'd0, abs_a};
                     divisor_q <= abs_b;
                     sign_q    <= signed_div && (reg1_i[31] ^ reg2_i[31]);
                     sign_r    <= signed_div && reg1_i[31];
                     cnt       <= '0;
                     state     <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               rem_q <= rem_next;
               if (cnt == CNT_LAST) begin
                  res_lo <= sign_q ? -rem_next[31:0]  : rem_next[31:0];
                  res_hi <= sign_r ? -rem_next[63:32] : rem_next[63:32];
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign sum  = reg1_i + reg2_i;
   assign diff = reg1_i - reg2_i;

   always_comb begin
      logic_res = '0;
      case (aluop_i)
         EXE_AND_OP: logic_res = reg1_i & reg2_i;
         EXE_OR_OP:  logic_res = reg1_i | reg2_i;
         EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
         EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
         default:    logic_res = '0;
      endcase
   end

   always_comb begin
      shift_res = '0;
      case (aluop_i)
         EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
         EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
         EXE_SRA_OP: shift_res = 32'($signed(reg2_i) >>> reg1_i[4:0]);
         default:    shift_res = '0;
      endcase
   end

   always_comb begin
      arith_res = '0;
      ov        = 1'b0;
      case (aluop_i)
         EXE_ADD_OP: begin
            arith_res = sum;
            ov        = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
         end
         EXE_ADDU_OP: arith_res = sum;
         EXE_SUB_OP: begin
            arith_res = diff;
            ov        = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
         end
         EXE_SUBU_OP: arith_res = diff;
         EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
         EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
         default:     arith_res = '0;
      endcase
   end

   always_comb begin
      result = '0;
      case (alusel_i)
         EXE_RES_NOP:        result = '0;
         EXE_RES_LOGIC:      result = logic_res;
         EXE_RES_SHIFT:      result = shift_res;
         EXE_RES_ARITHMETIC: result = arith_res;
         default:            result = '0;
      endcase
   end

   assign wd_o       = rst ? 5'd0  : wd_i;
   assign wreg_o     = !rst && wreg_i && !ov && !is_div;
   assign wdata_o    = rst ? 32'd0 : result;
   assign whilo_o    = !rst && (state == S_DONE);
   assign hi_o       = whilo_o ? res_hi : 32'd0;
   assign lo_o       = whilo_o ? res_lo : 32'd0;
   assign stallreq_o = !rst && (((state == S_IDLE) && is_div) || (state == S_BUSY));

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU vectors plus divider stall/result
// timing, with expected results queued at stimulus time and popped at output.
module tb_ex_stage;

   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_ARITH = 3'b100;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_AND  = 8'b0010_0100;
   localparam logic [7:0] OP_OR   = 8'b0010_0101;
   localparam logic [7:0] OP_XOR  = 8'b0010_0110;
   localparam logic [7:0] OP_NOR  = 8'b0010_0111;
   localparam logic [7:0] OP_SLL  = 8'b0111_1100;
   localparam logic [7:0] OP_SRL  = 8'b0000_0010;
   localparam logic [7:0] OP_SRA  = 8'b0000_0011;
   localparam logic [7:0] OP_SLT  = 8'b0010_1010;
   localparam logic [7:0] OP_SLTU = 8'b0010_1011;
   localparam logic [7:0] OP_ADD  = 8'b0010_0000;
   localparam logic [7:0] OP_ADDU = 8'b0010_0001;
   localparam logic [7:0] OP_SUB  = 8'b0010_0010;
   localparam logic [7:0] OP_SUBU = 8'b0010_0011;
   localparam logic [7:0] OP_DIV  = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU = 8'b0001_1011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  alusel_i;
   logic [7:0]  aluop_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        whilo_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        stallreq_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [2:0]  sel;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_d;
      logic        exp_w;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] wdata;
      logic        wreg;
      logic [4:0]  wd;
   } alu_exp_t;

   typedef struct {
      string       name;
      int          stalls;
      logic [31:0] hi;
      logic [31:0] lo;
   } div_exp_t;

   alu_exp_t alu_q[$];
   div_exp_t div_q[$];

   ex_stage #(.DIV_CYCLES(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .alusel_i   (alusel_i),
      .aluop_i    (aluop_i),
      .reg1_i     (reg1_i),
      .reg2_i     (reg2_i),
      .wd_i       (wd_i),
      .wreg_i     (wreg_i),
      .wd_o       (wd_o),
      .wreg_o     (wreg_o),
      .wdata_o    (wdata_o),
      .whilo_o    (whilo_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .stallreq_o (stallreq_o)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr);
      alusel_i = sel;
      aluop_i  = op;
      reg1_i   = a;
      reg2_i   = b;
      wd_i     = wd;
      wreg_i   = wr;
   endtask

   // Launches a divide at the start of a cycle and measures the stall run;
   // returns sampled at the negedge of the first non-stalled cycle.
   task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output int early_strobes, output logic wreg_t0,
                         output logic whilo, output logic [31:0] hi, output logic [31:0] lo,
                         output bit timeout);
      @(posedge clk); #1;
      drive(SEL_NOP, op, a, b, 5'd7, 1'b1);
      stalls        = 0;
      early_strobes = 0;
      timeout       = 1'b0;
      wreg_t0       = 1'b0;
      forever begin
         @(negedge clk);
         if (stalls == 0) wreg_t0 = wreg_o;
         if (!stallreq_o) break;
         stalls++;
         if (whilo_o) early_strobes++;
         if (stalls > 100) begin
            timeout = 1'b1;
            break;
         end
      end
      whilo = whilo_o;
      hi    = hi_o;
      lo    = lo_o;
   endtask

   task automatic test_reset();
      drive(SEL_ARITH, OP_DIV, 32'd7, 32'd2, 5'd3, 1'b1);
      #12;
      checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL rst_stallreq got=%b exp=0", stallreq_o); end
      checks++; if (whilo_o !== 1'b0) begin failures++; $display("FAIL rst_whilo got=%b exp=0", whilo_o); end
      checks++; if (wd_o !== 5'd0) begin failures++; $display("FAIL rst_wd got=%h exp=0", wd_o); end
      drive(SEL_ARITH, OP_ADD, 32'd5, 32'd6, 5'd9, 1'b1);
      #1;
      checks++; if (wdata_o !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", wdata_o); end
      checks++; if (wreg_o !== 1'b0) begin failures++; $display("FAIL rst_wreg got=%b exp=0", wreg_o); end
      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL post_rst_stall got=%b exp=0", stallreq_o); end
      checks++; if ({hi_o, lo_o} !== 64'd0) begin failures++; $display("FAIL post_rst_hilo got=%h exp=0", {hi_o, lo_o}); end
   endtask

   task automatic test_logic_shift();
      vec_t v[$];
      alu_exp_t e;
      v.push_back('{"and",  SEL_LOGIC, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b1});
      v.push_back('{"or",   SEL_LOGIC, OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b1});
      v.push_back('{"xor",  SEL_LOGIC, OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b1});
      v.push_back('{"nor",  SEL_LOGIC, OP_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0});
      v.push_back('{"badop",SEL_LOGIC, 8'hFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
      v.push_back('{"sll",  SEL_SHIFT, OP_SLL, 32'd31,        32'h0000_0001, 32'h8000_0000, 1'b1});
      v.push_back('{"srl",  SEL_SHIFT, OP_SRL, 32'd4,         32'h8000_0010, 32'h0800_0001, 1'b1});
      v.push_back('{"sra",  SEL_SHIFT, OP_SRA, 32'd4,         32'h8000_0010, 32'hF800_0001, 1'b1});
      v.push_back('{"sra5b",SEL_SHIFT, OP_SRA, 32'h0000_0024, 32'h8000_0010, 32'hF800_0001, 1'b1});
      v.push_back('{"srapos",SEL_SHIFT,OP_SRA, 32'd30,        32'h4000_0000, 32'h0000_0001, 1'b1});
      foreach (v[i]) begin
         @(posedge clk); #1;
         drive(v[i].sel, v[i].op, v[i].a, v[i].b, 5'(i + 1), 1'b1);
         alu_q.push_back('{v[i].name, v[i].exp_d, 1'b1, 5'(i + 1)});
         @(negedge clk);
         e = alu_q.pop_front();
         checks++; if (wdata_o !== e.wdata) begin failures++; $display("FAIL %s wdata got=%h exp=%h", e.name, wdata_o, e.wdata); end
         checks++; if (wreg_o !== e.wreg) begin failures++; $display("FAIL %s wreg got=%b exp=%b", e.name, wreg_o, e.wreg); end
         checks++; if (wd_o !== e.wd) begin failures++; $display("FAIL %s wd got=%h exp=%h", e.name, wd_o, e.wd); end
      end
   endtask

   task automatic test_arith();
      vec_t v[$];
      alu_exp_t e;
      v.push_back('{"add_ov",  SEL_ARITH, OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0});
      v.push_back('{"addu",    SEL_ARITH, OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1});
      v.push_back('{"add_neg", SEL_ARITH, OP_ADD,  32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1});
      v.push_back('{"sub_ov",  SEL_ARITH, OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0});
      v.push_back('{"sub",     SEL_ARITH, OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1});
      v.push_back('{"subu",    SEL_ARITH, OP_SUBU, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1});
      v.push_back('{"slt",     SEL_ARITH, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1});
      v.push_back('{"sltu",    SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1});
      v.push_back('{"nop",     SEL_NOP,   OP_ADD,  32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1});
      foreach (v[i]) begin
         @(posedge clk); #1;
         drive(v[i].sel, v[i].op, v[i].a, v[i].b, 5'(i + 16), 1'b1);
         alu_q.push_back('{v[i].name, v[i].exp_d, v[i].exp_w, 5'(i + 16)});
         @(negedge clk);
         e = alu_q.pop_front();
         checks++; if (wdata_o !== e.wdata) begin failures++; $display("FAIL %s wdata got=%h exp=%h", e.name, wdata_o, e.wdata); end
         checks++; if (wreg_o !== e.wreg) begin failures++; $display("FAIL %s wreg got=%b exp=%b", e.name, wreg_o, e.wreg); end
         checks++; if (wd_o !== e.wd) begin failures++; $display("FAIL %s wd got=%h exp=%h", e.name, wd_o, e.wd); end
      end
   endtask

   task automatic test_div_signed();
      div_exp_t e;
      int st, es; logic w0, wh; logic [31:0] hi, lo; bit to;
      div_q.push_back('{"div_m7_2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, st, es, w0, wh, hi, lo, to);
      e = div_q.pop_front();
      checks++; if (to) begin failures++; $display("FAIL %s timeout stalls=%0d limit=100", e.name, st); end
      checks++; if (st != e.stalls) begin failures++; $display("FAIL %s stalls got=%0d exp=%0d", e.name, st, e.stalls); end
      checks++; if (es != 0) begin failures++; $display("FAIL %s early_strobe got=%0d exp=0", e.name, es); end
      checks++; if (w0 !== 1'b0) begin failures++; $display("FAIL %s wreg got=%b exp=0", e.name, w0); end
      checks++; if (wh !== 1'b1) begin failures++; $display("FAIL %s whilo got=%b exp=1", e.name, wh); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", e.name, lo, e.lo); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", e.name, hi, e.hi); end
      @(posedge clk); #1;
      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      checks++; if (whilo_o !== 1'b0) begin failures++; $display("FAIL div_strobe_width whilo got=%b exp=0", whilo_o); end
      checks++; if (lo_o !== 32'd0) begin failures++; $display("FAIL div_lo_idle got=%h exp=0", lo_o); end
   endtask

   task automatic test_divu();
      div_exp_t e;
      int st, es; logic w0, wh; logic [31:0] hi, lo; bit to;
      div_q.push_back('{"divu_big", 33, 32'h0000_000F, 32'h0FFF_FFFF});
      do_div(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, st, es, w0, wh, hi, lo, to);
      e = div_q.pop_front();
      checks++; if (to) begin failures++; $display("FAIL %s timeout stalls=%0d limit=100", e.name, st); end
      checks++; if (st != e.stalls) begin failures++; $display("FAIL %s stalls got=%0d exp=%0d", e.name, st, e.stalls); end
      checks++; if (wh !== 1'b1) begin failures++; $display("FAIL %s whilo got=%b exp=1", e.name, wh); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", e.name, lo, e.lo); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", e.name, hi, e.hi); end
   endtask

   task automatic test_div_zero();
      div_exp_t e;
      int st, es; logic w0, wh; logic [31:0] hi, lo; bit to;
      div_q.push_back('{"div_zero", 1, 32'd0, 32'd0});
      do_div(OP_DIV, 32'h1234_5678, 32'd0, st, es, w0, wh, hi, lo, to);
      e = div_q.pop_front();
      checks++; if (to) begin failures++; $display("FAIL %s timeout stalls=%0d limit=100", e.name, st); end
      checks++; if (st != e.stalls) begin failures++; $display("FAIL %s stalls got=%0d exp=%0d", e.name, st, e.stalls); end
      checks++; if (wh !== 1'b1) begin failures++; $display("FAIL %s whilo got=%b exp=1", e.name, wh); end
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin failures++; $display("FAIL %s hilo got=%h exp=%h", e.name, {hi, lo}, {e.hi, e.lo}); end
   endtask

   task automatic test_back_to_back();
      div_exp_t e;
      int st, es; logic w0, wh; logic [31:0] hi, lo; bit to;
      div_q.push_back('{"div_minint", 33, 32'h0000_0000, 32'h8000_0000});
      div_q.push_back('{"div_100_m7", 33, 32'h0000_0002, 32'hFFFF_FFF2});
      for (int k = 0; k < 2; k++) begin
         if (k == 0) do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, es, w0, wh, hi, lo, to);
         else        do_div(OP_DIV, 32'd100, 32'hFFFF_FFF9, st, es, w0, wh, hi, lo, to);
         e = div_q.pop_front();
         checks++; if (to) begin failures++; $display("FAIL %s timeout stalls=%0d limit=100", e.name, st); end
         checks++; if (st != e.stalls) begin failures++; $display("FAIL %s stalls got=%0d exp=%0d", e.name, st, e.stalls); end
         checks++; if (es != 0) begin failures++; $display("FAIL %s early_strobe got=%0d exp=0", e.name, es); end
         checks++; if (wh !== 1'b1) begin failures++; $display("FAIL %s whilo got=%b exp=1", e.name, wh); end
         checks++; if (lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", e.name, lo, e.lo); end
         checks++; if (hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", e.name, hi, e.hi); end
      end
      @(posedge clk); #1;
      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      checks++; if ({whilo_o, stallreq_o} !== 2'b00) begin failures++; $display("FAIL b2b_tail whilo_stall got=%b exp=00", {whilo_o, stallreq_o}); end
   endtask

   task automatic test_reset_mid_busy();
      div_exp_t e;
      int st, es; logic w0, wh; logic [31:0] hi, lo; bit to;
      @(posedge clk); #1;
      drive(SEL_NOP, OP_DIV, 32'd1000, 32'd3, 5'd4, 1'b1);
      repeat (11) @(posedge clk);
      #2;
      checks++; if (stallreq_o !== 1'b1) begin failures++; $display("FAIL busy_pre_rst stall got=%b exp=1", stallreq_o); end
      rst = 1'b1;
      #1;
      checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL busy_rst stall got=%b exp=0", stallreq_o); end
      checks++; if ({whilo_o, wreg_o, wdata_o} !== 34'd0) begin failures++; $display("FAIL busy_rst outs got=%h exp=0", {whilo_o, wreg_o, wdata_o}); end
      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++; if ({whilo_o, stallreq_o} !== 2'b00) begin failures++; $display("FAIL post_busy_rst whilo_stall got=%b exp=00", {whilo_o, stallreq_o}); end
      div_q.push_back('{"div_100_7", 33, 32'd2, 32'd14});
      do_div(OP_DIV, 32'd100, 32'd7, st, es, w0, wh, hi, lo, to);
      e = div_q.pop_front();
      checks++; if (to) begin failures++; $display("FAIL %s timeout stalls=%0d limit=100", e.name, st); end
      checks++; if (st != e.stalls) begin failures++; $display("FAIL %s stalls got=%0d exp=%0d", e.name, st, e.stalls); end
      checks++; if (wh !== 1'b1) begin failures++; $display("FAIL %s whilo got=%b exp=1", e.name, wh); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL %s lo got=%h exp=%h", e.name, lo, e.lo); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL %s hi got=%h exp=%h", e.name, hi, e.hi); end
      @(posedge clk); #1;
      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   initial begin
      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      test_reset();
      test_logic_shift();
      test_arith();
      test_div_signed();
      test_divu();
      test_div_zero();
      test_back_to_back();
      test_reset_mid_busy();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
